// File: rtl/seg7_scan_capture_if.sv
// Scanned 7-segment bus (AN/HEX) plus the decoded frame outputs of the capture block.
// Combinational bundle only; master drives the display pins, slave is the capture block.
interface seg7_scan_capture_if #(
  parameter int FRAME_CNT_W = 16
);
  logic [7:0]             AN;
  logic [7:0]             HEX;
  logic [31:0]            value;
  logic [7:0]             dp;
  logic [7:0]             blank;
  logic [7:0]             err;
  logic                   frame_valid;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   value_chg;

  modport master (
    output AN, HEX,
    input  value, dp, blank, err, frame_valid, frame_count, value_chg
  );

  modport slave (
    input  AN, HEX,
    output value, dp, blank, err, frame_valid, frame_count, value_chg
  );
endinterface

// File: rtl/seg7_scan_capture.sv
// Decodes a scanned 8-digit 7-segment bus back into hex frames; SEG7_CHANGE_DETECT_EN adds value_chg.
// Latency: last digit AN edge -> frame_valid = 1 + SETTLE_CYCLES + 1 cycles.
// No backpressure: passive monitor, outputs hold until the next complete frame.
module seg7_scan_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int FRAME_CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_capture_if.slave bus
);
  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [7:0]             an_q, an_d1_q, hex_q;
  logic [7:0]             cnt_q, cnt_d, cnt_eff;
  logic                   an_valid, sample, complete;
  logic [2:0]             sel;
  logic [3:0]             nib;
  logic                   dec_blank, dec_err;
  logic [7:0][3:0]        sh_nib_q, sh_nib_d;
  logic [7:0]             sh_dp_q, sh_dp_d, sh_blank_q, sh_blank_d, sh_err_q, sh_err_d;
  logic [7:0]             seen_q, seen_d;
  logic [31:0]            value_q;
  logic [7:0]             dp_q, blank_q, err_q;
  logic                   fv_q;
  logic [FRAME_CNT_W-1:0] fc_q;

  always_comb begin
    an_valid = $onehot(~an_q);
    sel      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_q[i]) sel = 3'(i);
    end
  end

  // A change of the registered select restarts the dwell; the sample is taken on
  // the cycle the count would first reach SETTLE.
  always_comb begin
    cnt_eff = (an_q != an_d1_q) ? 8'd0 : cnt_q;
    if (!an_valid)              cnt_d = 8'd0;
    else if (cnt_eff == SETTLE) cnt_d = SETTLE;
    else                        cnt_d = cnt_eff + 8'd1;
    sample = an_valid && (cnt_d == SETTLE) && (cnt_eff != SETTLE);
  end

  always_comb begin
    nib       = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (~hex_q[6:0])
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_err = 1'b1;
    endcase
  end

  // A sample coinciding with frame completion starts the next frame.
  always_comb begin
    complete   = (seen_q == 8'hFF);
    seen_d     = complete ? 8'h00 : seen_q;
    sh_nib_d   = sh_nib_q;
    sh_dp_d    = sh_dp_q;
    sh_blank_d = sh_blank_q;
    sh_err_d   = sh_err_q;
    if (sample) begin
      seen_d[sel]     = 1'b1;
      sh_nib_d[sel]   = nib;
      sh_dp_d[sel]    = ~hex_q[7];
      sh_blank_d[sel] = dec_blank;
      sh_err_d[sel]   = dec_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= 8'h00;
      an_d1_q    <= 8'h00;
      hex_q      <= 8'h00;
      cnt_q      <= 8'h00;
      seen_q     <= 8'h00;
      sh_nib_q   <= '0;
      sh_dp_q    <= 8'h00;
      sh_blank_q <= 8'h00;
      sh_err_q   <= 8'h00;
      value_q    <= 32'h0;
      dp_q       <= 8'h00;
      blank_q    <= 8'h00;
      err_q      <= 8'h00;
      fv_q       <= 1'b0;
      fc_q       <= '0;
    end else begin
      an_q       <= bus.AN;
      an_d1_q    <= an_q;
      hex_q      <= bus.HEX;
      cnt_q      <= cnt_d;
      seen_q     <= seen_d;
      sh_nib_q   <= sh_nib_d;
      sh_dp_q    <= sh_dp_d;
      sh_blank_q <= sh_blank_d;
      sh_err_q   <= sh_err_d;
      fv_q       <= complete;
      if (complete) begin
        value_q <= sh_nib_q;
        dp_q    <= sh_dp_q;
        blank_q <= sh_blank_q;
        err_q   <= sh_err_q;
        fc_q    <= fc_q + 1'b1;
      end
    end
  end

`ifdef SEG7_CHANGE_DETECT_EN
  // The output registers already hold the previous frame, so only a first-frame flag is added.
  logic first_q, chg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      chg_q <= complete && (first_q || ({sh_nib_q, sh_dp_q} != {value_q, dp_q}));
      if (complete) first_q <= 1'b0;
    end
  end

  assign bus.value_chg = chg_q;
`else
  assign bus.value_chg = 1'b0;
`endif

  assign bus.value       = value_q;
  assign bus.dp          = dp_q;
  assign bus.blank       = blank_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.frame_count = fc_q;
endmodule
